prod_accumulator: RTL and testbench

PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

---
 rtl/prod_acc_pkg.sv | 14 +
 rtl/sat_add.sv | 23 ++
 rtl/prod_accumulator.sv | 129 ++++++++++++
 tb/tb_prod_accumulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the product accumulator slice.
package prod_acc_pkg;

  localparam int unsigned ACC_W_DEF     = 24;
  localparam int unsigned MAX_TERMS_DEF = 256;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned PROD_W        = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Unsigned adder of a 16-bit product into an ACC_W accumulator, clamped at all-ones.
module sat_add
  import prod_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] full;

  always_comb begin
    full = SUM_W'(a) + SUM_W'(b);
    ovf  = full[ACC_W];
    sum  = ovf ? '1 : full[ACC_W-1:0];
  end

endmodule

// File: rtl/prod_accumulator.sv
// Accumulates a stream of 8x8 products into saturated per-frame sums with
// a single-entry result register and valid/ready handshakes on both sides.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output logic              out_forced
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_sat_q, out_sat_d;
  logic               out_forced_q, out_forced_d;

  logic [ACC_W-1:0]   acc_base;
  logic [CNT_W-1:0]   count_base;
  logic [CNT_W-1:0]   count_inc;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic               in_xfer;
  logic               out_xfer;
  logic               frame_close;

  // The only stall source is an unconsumed result that is not leaving this cycle.
  assign in_ready = !out_valid_q || out_ready;

  // A fresh frame always starts from zero, regardless of leftover register contents.
  assign acc_base   = (state_q == IDLE) ? '0 : acc_q;
  assign count_base = (state_q == IDLE) ? '0 : count_q;

  sat_add #(
    .ACC_W(ACC_W)
  ) u_sat_add (
    .a  (acc_base),
    .b  (in_prod),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    sat_d        = sat_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_count_d  = out_count_q;
    out_sat_d    = out_sat_q;
    out_forced_d = out_forced_q;

    in_xfer     = in_valid && in_ready;
    out_xfer    = out_valid_q && out_ready;
    count_inc   = count_base + CNT_W'(1);
    frame_close = in_xfer && (in_last || (count_inc == CNT_W'(MAX_TERMS)));

    if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    if (in_xfer) begin
      if (frame_close) begin
        // Result includes the closing term; it may overwrite a result leaving this cycle.
        state_d      = IDLE;
        acc_d        = '0;
        count_d      = '0;
        sat_d        = 1'b0;
        out_valid_d  = 1'b1;
        out_sum_d    = add_sum;
        out_count_d  = count_inc;
        out_sat_d    = sat_q || add_ovf;
        out_forced_d = !in_last;
      end else begin
        state_d = ACCUM;
        acc_d   = add_sum;
        count_d = count_inc;
        sat_d   = sat_q || add_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      count_q      <= '0;
      sat_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_count_q  <= '0;
      out_sat_q    <= 1'b0;
      out_forced_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      sat_q        <= sat_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_count_q  <= out_count_d;
      out_sat_q    <= out_sat_d;
      out_forced_q <= out_forced_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_count  = out_count_q;
  assign out_sat    = out_sat_q;
  assign out_forced = out_forced_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench for prod_accumulator: directed frames plus random traffic
// checked against a frame-level arithmetic model.
module tb_prod_accumulator;

  localparam int unsigned ACC_W     = 17;
  localparam int unsigned MAX_TERMS = 4;
  localparam longint      SUM_MAX   = (longint'(1) << ACC_W) - 1;
  localparam int          N_RANDOM  = 40000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_prod = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_sum;
  logic [15:0]       out_count;
  logic              out_sat;
  logic              out_forced;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    longint sum;
    int     cnt;
    bit     sat;
    bit     forced;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  exp_t   mdl_e;
  longint frame_total = 0;
  int     frame_cnt   = 0;
  bit     mdl_valid   = 1'b0;

  prod_accumulator #(
    .ACC_W    (ACC_W),
    .MAX_TERMS(MAX_TERMS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_sat   (out_sat),
    .out_forced(out_forced)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: clamped running sum of non-negative terms equals min(total, max).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_total = 0;
      frame_cnt   = 0;
      mdl_valid   = 1'b0;
      exp_q.delete();
    end else begin
      bit rdy;
      bit take;
      rdy  = !mdl_valid || out_ready;
      take = in_valid && rdy;
      if (mdl_valid && out_ready) mdl_valid = 1'b0;
      if (take) begin
        frame_total += longint'(in_prod);
        frame_cnt++;
        if (in_last || frame_cnt == int'(MAX_TERMS)) begin
          mdl_e.sum    = (frame_total > SUM_MAX) ? SUM_MAX : frame_total;
          mdl_e.cnt    = frame_cnt;
          mdl_e.sat    = frame_total > SUM_MAX;
          mdl_e.forced = !in_last;
          exp_q.push_back(mdl_e);
          mdl_valid   = 1'b1;
          frame_total = 0;
          frame_cnt   = 0;
        end
      end
    end
  end

  // Monitor: compares every presented result with the queue head, pops on consumption.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", longint'(in_ready), longint'(!mdl_valid || out_ready));
      chk("out_valid", longint'(out_valid), longint'(mdl_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q[0];
          chk("out_sum", longint'(out_sum), mon_e.sum);
          chk("out_count", longint'(out_count), longint'(mon_e.cnt));
          chk("out_sat", longint'(out_sat), longint'(mon_e.sat));
          chk("out_forced", longint'(out_forced), longint'(mon_e.forced));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [15:0] p, input bit l, input bit ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = ordy;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_sum"}, longint'(out_sum), 0);
    chk({tag, "_out_count"}, longint'(out_count), 0);
    chk({tag, "_out_sat"}, longint'(out_sat), 0);
    chk({tag, "_out_forced"}, longint'(out_forced), 0);
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
  endtask

  task automatic wait_result(input string name, input longint sum, input int cnt,
                             input bit sat, input bit forced);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_seen"}, longint'(seen), 1);
    if (seen) begin
      chk({name, "_sum"}, longint'(out_sum), sum);
      chk({name, "_count"}, longint'(out_count), longint'(cnt));
      chk({name, "_sat"}, longint'(out_sat), longint'(sat));
      chk({name, "_forced"}, longint'(out_forced), longint'(forced));
    end
  endtask

  initial begin
    logic [15:0] p;

    // Power-on reset
    check_reset_outputs("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Three-term frame, result one cycle after the closing transfer
    cyc(1, 16'd100, 0, 1);
    cyc(1, 16'd200, 0, 1);
    cyc(1, 16'd300, 1, 1);
    @(negedge clk);
    chk("lat_before_edge", longint'(out_valid), 0);
    cyc(0, 16'd0, 0, 1);
    @(negedge clk);
    chk("f600_valid", longint'(out_valid), 1);
    chk("f600_sum", longint'(out_sum), 600);
    chk("f600_count", longint'(out_count), 3);
    chk("f600_sat", longint'(out_sat), 0);
    chk("f600_forced", longint'(out_forced), 0);
    cyc(0, 16'd0, 0, 1);
    @(negedge clk);
    chk("f600_consumed", longint'(out_valid), 0);

    // Saturation at 2^17-1
    cyc(1, 16'd65025, 0, 1);
    cyc(1, 16'd65025, 0, 1);
    cyc(1, 16'd65025, 1, 1);
    cyc(0, 16'd0, 0, 1);
    wait_result("sat", 131071, 3, 1, 0);
    cyc(0, 16'd0, 0, 1);

    // Forced close at MAX_TERMS; fifth term opens a new frame
    for (int i = 0; i < 4; i++) cyc(1, 16'd1, 0, 1);
    cyc(1, 16'd1, 0, 1);
    @(negedge clk);
    chk("forced_valid", longint'(out_valid), 1);
    chk("forced_count", longint'(out_count), 4);
    chk("forced_sum", longint'(out_sum), 4);
    chk("forced_flag", longint'(out_forced), 1);
    cyc(1, 16'd0, 1, 1);
    cyc(0, 16'd0, 0, 1);
    wait_result("after_forced", 1, 2, 0, 0);
    cyc(0, 16'd0, 0, 1);

    // Backpressure: stalled result stays put, then replaced without a valid gap
    cyc(1, 16'd5, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 16'd9, 1, 0);
      @(negedge clk);
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_valid", longint'(out_valid), 1);
      chk("stall_sum", longint'(out_sum), 5);
      chk("stall_count", longint'(out_count), 1);
    end
    cyc(1, 16'd11, 1, 1);
    @(negedge clk);
    chk("replace_in_ready", longint'(in_ready), 1);
    cyc(0, 16'd0, 0, 0);
    @(negedge clk);
    chk("replace_valid", longint'(out_valid), 1);
    chk("replace_sum", longint'(out_sum), 11);
    cyc(0, 16'd0, 0, 1);
    cyc(0, 16'd0, 0, 1);

    // Reset mid-frame discards the partial frame
    cyc(1, 16'd50, 0, 1);
    cyc(1, 16'd60, 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 16'd7, 0, 1);
    cyc(1, 16'd8, 1, 1);
    cyc(0, 16'd0, 0, 1);
    wait_result("post_rst", 15, 2, 0, 0);
    cyc(0, 16'd0, 0, 1);

    // Random traffic
    for (int i = 0; i < N_RANDOM; i++) begin
      case ($urandom % 4)
        0:       p = 16'd65025;
        1:       p = 16'($urandom % 256);
        default: p = 16'($urandom % 65536);
      endcase
      cyc(($urandom % 10) < 7, p, ($urandom % 4) == 0, ($urandom % 10) < 6);
    end

    // Drain and confirm nothing left unconsumed
    for (int i = 0; i < 4; i++) cyc(0, 16'd0, 0, 1);
    @(negedge clk);
    chk("queue_drained", longint'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
